// File: rtl/enc_sample_scheduler.sv
// ---------------------------------------------------------------------------
// enc_sample_scheduler
//   Periodic sampling controller for a bank of quadrature-encoder counters.
//   On each sample tick all channel counts are snapshotted in one cycle. A
//   single shared subtractor then computes the per-channel deltas, one channel
//   per cycle. Each delta is saturated to a signed DW-bit value and published
//   into a readout bank that the host reads.
//
// Ports
//   clk        : system clock
//   reset_n    : synchronous active-low reset
//   enable     : sampling enable (the period timer is held at 0 when low)
//   enc_counts : flattened 32-bit channel counts, channel i at [32i+31:32i]
//   rd_req     : host read strobe, single cycle
//   rd_addr    : channel index to read
//   data_clr   : host has consumed the sample; clears data_valid
//   rd_data    : delta of the addressed channel (signed, DW bits)
//   rd_ack     : one-cycle pulse, rd_data valid
//   data_valid : a new sample set is available
//   overrun    : sticky, a publish happened while data_valid was still set
//   sample_id  : publish counter, wraps 255 -> 0
//   busy       : sequencer is not idle
// ---------------------------------------------------------------------------
module enc_sample_scheduler #(
  parameter int N_CH   = 4,
  parameter int PERIOD = 50000,
  parameter int DW     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [32*N_CH-1:0]   enc_counts,
  input  logic                 rd_req,
  input  logic [2:0]           rd_addr,
  input  logic                 data_clr,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_ack,
  output logic                 data_valid,
  output logic                 overrun,
  output logic [7:0]           sample_id,
  output logic                 busy
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_CALC  = 2'd2;
  localparam logic [1:0] S_PUB   = 2'd3;

  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (DW - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -SAT_MAX - 32'sd1;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          primed_q, primed_d;
  logic [7:0]    sample_id_q, sample_id_d;
  logic          dv_q, dv_d;
  logic          ovr_q, ovr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_ack_q, rd_ack_d;

  logic [31:0]   snap_q [N_CH];
  logic [31:0]   prev_q [N_CH];
  logic [DW-1:0] work_q [N_CH];
  logic [DW-1:0] out_q  [N_CH];

  logic                 tick;
  logic [31:0]          snap_sel;
  logic [31:0]          prev_sel;
  logic signed [31:0]   delta;
  logic [DW-1:0]        sat_val;

  // Period timer and sequencer next-state
  always_comb begin
    tick    = enable && (timer_q == TW'(PERIOD - 1));
    timer_d = '0;
    if (enable && !tick) begin
      timer_d = timer_q + TW'(1);
    end

    state_d     = state_q;
    idx_d       = idx_q;
    primed_d    = primed_q;
    sample_id_d = sample_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        idx_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (idx_q == IW'(N_CH - 1)) begin
          state_d = S_PUB;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_PUB: begin
        sample_id_d = sample_id_q + 8'd1;
        primed_d    = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shared subtractor: select the current channel, then saturate.
  // 32-bit modular subtraction gives the right delta across counter wrap.
  always_comb begin
    snap_sel = '0;
    prev_sel = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (idx_q == IW'(i)) begin
        snap_sel = snap_q[i];
        prev_sel = prev_q[i];
      end
    end
    delta = snap_sel - prev_sel;
    if (delta > SAT_MAX) begin
      sat_val = SAT_MAX[DW-1:0];
    end else if (delta < SAT_MIN) begin
      sat_val = SAT_MIN[DW-1:0];
    end else begin
      sat_val = delta[DW-1:0];
    end
  end

  // Handshake flags. A clear coincident with a publish is applied first,
  // so the publish leaves data_valid set and does not count as an overrun.
  always_comb begin
    dv_d  = dv_q;
    ovr_d = ovr_q;
    if (state_q == S_PUB) begin
      if (dv_q && !data_clr) begin
        ovr_d = 1'b1;
      end
      dv_d = 1'b1;
    end else if (data_clr) begin
      dv_d = 1'b0;
    end
  end

  // Host read: out_q only changes on the publish edge, so a read issued in
  // the publish cycle sees the previous sample set.
  always_comb begin
    rd_ack_d  = rd_req;
    rd_data_d = rd_data_q;
    if (rd_req) begin
      rd_data_d = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (32'(rd_addr) == i) begin
          rd_data_d = out_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      primed_q    <= 1'b0;
      sample_id_q <= '0;
      dv_q        <= 1'b0;
      ovr_q       <= 1'b0;
      rd_data_q   <= '0;
      rd_ack_q    <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        snap_q[i] <= '0;
        prev_q[i] <= '0;
        work_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      primed_q    <= primed_d;
      sample_id_q <= sample_id_d;
      dv_q        <= dv_d;
      ovr_q       <= ovr_d;
      rd_data_q   <= rd_data_d;
      rd_ack_q    <= rd_ack_d;

      if (state_q == S_LATCH) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          snap_q[i] <= enc_counts[32*i +: 32];
        end
      end

      // The first sample after reset only primes prev; its deltas read 0.
      if (state_q == S_CALC) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (idx_q == IW'(i)) begin
            prev_q[i] <= snap_q[i];
            work_q[i] <= primed_q ? sat_val : '0;
          end
        end
      end

      if (state_q == S_PUB) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          out_q[i] <= work_q[i];
        end
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_ack     = rd_ack_q;
  assign data_valid = dv_q;
  assign overrun    = ovr_q;
  assign sample_id  = sample_id_q;
  assign busy       = (state_q != S_IDLE);

endmodule
